// File: rtl/rom_arbiter_if.sv
// rtl/rom_arbiter_if.sv - requester/ROM bus bundle for the ROM arbiter
//
// Groups the requester handshake and the ROM port of rom_arbiter.
//   req       requester -> arbiter  per-requester read request (level)
//   req_addr  requester -> arbiter  flattened addresses, requester i at [i*ADDR_W +: ADDR_W]
//   gnt       arbiter -> requester  one-hot grant pulse
//   rvalid    arbiter -> requester  one-hot read-data valid pulse
//   rdata     arbiter -> requester  shared read data, zero when no rvalid
//   rom_ena   arbiter -> ROM        read enable
//   rom_addr  arbiter -> ROM        read address
//   rom_dout  ROM -> arbiter        registered ROM output
// slave modport: the arbiter. master modport: requesters plus the ROM.
interface rom_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 14,
    parameter int DATA_W  = 8
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        rvalid;
    logic [DATA_W-1:0]         rdata;
    logic                      rom_ena;
    logic [ADDR_W-1:0]         rom_addr;
    logic [DATA_W-1:0]         rom_dout;

    modport slave (
        input  req, req_addr, rom_dout,
        output gnt, rvalid, rdata, rom_ena, rom_addr
    );

    modport master (
        output req, req_addr, rom_dout,
        input  gnt, rvalid, rdata, rom_ena, rom_addr
    );
endinterface

// File: rtl/rom_arbiter.sv
// rtl/rom_arbiter.sv - per-cycle arbiter sharing one registered-read ROM
//
// Shares a single-port ROM with a 1-cycle registered read between NUM_REQ
// requesters. One access may issue every cycle; latency is fixed:
// req sampled in T -> gnt/rom_ena/rom_addr in T+1 -> rvalid/rdata in T+2.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    rom_arbiter_if.slave (req, req_addr, gnt, rvalid, rdata,
//          rom_ena, rom_addr, rom_dout)
// Parameters: NUM_REQ (2..8), ADDR_W, DATA_W, RR_MODE (1 round-robin,
// 0 fixed priority with index 0 highest).
module rom_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 14,
    parameter int DATA_W  = 8,
    parameter int RR_MODE = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    rom_arbiter_if.slave  bus
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0] gnt_q;
    logic [NUM_REQ-1:0] rvalid_q;
    logic               ena_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [IDX_W-1:0]   last;

    logic [NUM_REQ-1:0] eligible;
    logic               win_found;
    logic [IDX_W-1:0]   win_idx;
    logic [NUM_REQ-1:0] win_onehot;
    logic [IDX_W:0]     cand;
    logic [ADDR_W-1:0]  addr_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_addr
        assign addr_arr[g] = bus.req_addr[g*ADDR_W +: ADDR_W];
    end

    // A requester that sees its own grant this cycle has already been
    // served; masking it lets it drop req or present the next address.
    assign eligible = bus.req & ~gnt_q;

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        if (RR_MODE != 0) begin
            // Search last+1, last+2, ... wrapping at NUM_REQ; one spare bit
            // in cand holds the unwrapped sum.
            for (int k = 1; k <= NUM_REQ; k++) begin
                cand = {1'b0, last} + (IDX_W+1)'(k);
                if (cand >= (IDX_W+1)'(NUM_REQ)) begin
                    cand = cand - (IDX_W+1)'(NUM_REQ);
                end
                if (!win_found && eligible[cand[IDX_W-1:0]]) begin
                    win_found = 1'b1;
                    win_idx   = cand[IDX_W-1:0];
                end
            end
        end else begin
            // Descending scan so the lowest eligible index is written last.
            for (int i = NUM_REQ - 1; i >= 0; i--) begin
                if (eligible[i]) begin
                    win_found = 1'b1;
                    win_idx   = IDX_W'(i);
                end
            end
        end
    end

    assign win_onehot = NUM_REQ'(1) << win_idx;

    // gnt_q doubles as the stage-1 tag: it marks which requester owns the
    // read the ROM is capturing, and moves to rvalid one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_q    <= '0;
            rvalid_q <= '0;
            ena_q    <= 1'b0;
            addr_q   <= '0;
            last     <= IDX_W'(NUM_REQ - 1);
        end else begin
            rvalid_q <= gnt_q;
            ena_q    <= win_found;
            gnt_q    <= win_found ? win_onehot : '0;
            if (win_found) begin
                addr_q <= addr_arr[win_idx];
                if (RR_MODE != 0) begin
                    last <= win_idx;
                end
            end
        end
    end

    assign bus.gnt      = gnt_q;
    assign bus.rvalid   = rvalid_q;
    assign bus.rom_ena  = ena_q;
    assign bus.rom_addr = addr_q;
    // ROM output is stale between reads; present zero unless a read lands.
    assign bus.rdata    = (|rvalid_q) ? bus.rom_dout : '0;

    a_gnt_onehot:    assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt_q));
    a_rvalid_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(rvalid_q));
    a_ena_matches:   assert property (@(posedge clk) disable iff (!rst_n) ena_q == (|gnt_q));
endmodule

// File: tb/tb_rom_arbiter.sv
// tb/tb_rom_arbiter.sv - scoreboard bench for rom_arbiter
module tb_rom_arbiter;
    logic clk;
    logic rst_n;

    int n_cmp;
    int n_fail;

    typedef struct packed {
        logic [1:0] v;
        logic [7:0] d;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    rom_arbiter_if #(.NUM_REQ(2), .ADDR_W(14), .DATA_W(8)) bus_a();
    rom_arbiter_if #(.NUM_REQ(2), .ADDR_W(14), .DATA_W(8)) bus_b();
    rom_arbiter_if #(.NUM_REQ(3), .ADDR_W(14), .DATA_W(8)) bus_c();

    rom_arbiter #(.NUM_REQ(2), .ADDR_W(14), .DATA_W(8), .RR_MODE(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a)
    );
    rom_arbiter #(.NUM_REQ(2), .ADDR_W(14), .DATA_W(8), .RR_MODE(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b)
    );
    rom_arbiter #(.NUM_REQ(3), .ADDR_W(14), .DATA_W(8), .RR_MODE(0)) dut_c (
        .clk(clk), .rst_n(rst_n), .bus(bus_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM model: mem[a] = a[7:0] ^ 8'hA5, one-cycle registered read.
    always @(posedge clk) begin
        if (bus_a.rom_ena) bus_a.rom_dout <= bus_a.rom_addr[7:0] ^ 8'hA5;
    end
    assign bus_b.rom_dout = 8'h00;
    assign bus_c.rom_dout = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every rvalid on requester bus A must match the head of the queue.
    always @(negedge clk) begin
        if (|bus_a.rvalid) begin
            if (sb.size() == 0) begin
                chk("unexpected_rvalid", 32'(bus_a.rvalid), 32'h0);
            end else begin
                mon_e = sb.pop_front();
                chk("rvalid", 32'(bus_a.rvalid), 32'(mon_e.v));
                chk("rdata", 32'(bus_a.rdata), 32'(mon_e.d));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input logic [1:0] r, input logic [13:0] a0, input logic [13:0] a1);
        bus_a.req      = r;
        bus_a.req_addr = {a1, a0};
    endtask

    task automatic push(input logic [1:0] v, input logic [7:0] d);
        exp_t e;
        e.v = v;
        e.d = d;
        sb.push_back(e);
    endtask

    task automatic chk_a_idle(input string name);
        chk({name, "_gnt"}, 32'(bus_a.gnt), 32'h0);
        chk({name, "_rvalid"}, 32'(bus_a.rvalid), 32'h0);
        chk({name, "_ena"}, 32'(bus_a.rom_ena), 32'h0);
        chk({name, "_rdata"}, 32'(bus_a.rdata), 32'h0);
    endtask

    task automatic do_reset();
        set_a(2'b00, 14'h0, 14'h0);
        bus_b.req = '0;
        bus_c.req = '0;
        rst_n = 1'b0;
        #1;
        chk_a_idle("rst");
        chk("rst_addr", 32'(bus_a.rom_addr), 32'h0);
        chk("rst_gnt_b", 32'(bus_b.gnt), 32'h0);
        chk("rst_gnt_c", 32'(bus_c.gnt), 32'h0);
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 10 && sb.size() != 0; i++) step();
        step();
        chk({name, "_sb_empty"}, 32'(sb.size()), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        bus_b.req_addr = {14'h0022, 14'h0011};
        bus_c.req_addr = {14'h0033, 14'h0022, 14'h0011};
        step();
        do_reset();

        // Single read
        set_a(2'b01, 14'h0010, 14'h0);
        push(2'b01, 8'hB5);
        step();
        chk("single_gnt", 32'(bus_a.gnt), 32'h1);
        chk("single_ena", 32'(bus_a.rom_ena), 32'h1);
        chk("single_addr", 32'(bus_a.rom_addr), 32'h0010);
        set_a(2'b00, 14'h0, 14'h0);
        step();
        chk("single_gnt_off", 32'(bus_a.gnt), 32'h0);
        chk("single_ena_off", 32'(bus_a.rom_ena), 32'h0);
        step();
        chk_a_idle("single_after");
        drain("single");

        // Round-robin contention
        do_reset();
        set_a(2'b11, 14'h0001, 14'h0002);
        for (int i = 0; i < 4; i++) push((i % 2 == 0) ? 2'b01 : 2'b10, (i % 2 == 0) ? 8'hA4 : 8'hA7);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rr_gnt", 32'(bus_a.gnt), (i % 2 == 0) ? 32'h1 : 32'h2);
            chk("rr_addr", 32'(bus_a.rom_addr), (i % 2 == 0) ? 32'h1 : 32'h2);
            if (i > 0) chk("rr_rvalid_nogap", 32'(bus_a.rvalid), (i % 2 == 0) ? 32'h2 : 32'h1);
        end
        set_a(2'b00, 14'h0, 14'h0);
        step();
        chk("rr_gnt_end", 32'(bus_a.gnt), 32'h0);
        drain("rr");

        // Withdrawal: requester 1 asserts for one cycle while 0 wins
        do_reset();
        set_a(2'b11, 14'h0030, 14'h0031);
        push(2'b01, 8'h95);
        step();
        chk("wd_gnt", 32'(bus_a.gnt), 32'h1);
        set_a(2'b00, 14'h0030, 14'h0031);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("wd_no_gnt1", 32'(bus_a.gnt[1]), 32'h0);
            chk("wd_addr_not1", 32'(bus_a.rom_addr == 14'h0031), 32'h0);
        end
        drain("wd");

        // Reset while a read is in flight
        do_reset();
        set_a(2'b01, 14'h0040, 14'h0);
        step();
        chk("mid_gnt", 32'(bus_a.gnt), 32'h1);
        set_a(2'b00, 14'h0, 14'h0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_a_idle("mid_rst");
        chk("mid_rst_addr", 32'(bus_a.rom_addr), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("mid_rvalid0", 32'(bus_a.rvalid), 32'h0);
        step();
        chk("mid_rvalid1", 32'(bus_a.rvalid), 32'h0);
        set_a(2'b11, 14'h0050, 14'h0051);
        push(2'b01, 8'hF5);
        push(2'b10, 8'hF4);
        step();
        chk("mid_first_gnt", 32'(bus_a.gnt), 32'h1);
        set_a(2'b10, 14'h0050, 14'h0051);
        step();
        chk("mid_second_gnt", 32'(bus_a.gnt), 32'h2);
        set_a(2'b00, 14'h0, 14'h0);
        drain("mid");

        // Back-to-back same requester
        do_reset();
        set_a(2'b01, 14'h0100, 14'h0);
        push(2'b01, 8'hA5);
        push(2'b01, 8'hA4);
        step();
        chk("b2b_gnt0", 32'(bus_a.gnt), 32'h1);
        chk("b2b_addr0", 32'(bus_a.rom_addr), 32'h0100);
        set_a(2'b01, 14'h0101, 14'h0);
        step();
        chk("b2b_gap", 32'(bus_a.gnt), 32'h0);
        chk("b2b_gap_ena", 32'(bus_a.rom_ena), 32'h0);
        step();
        chk("b2b_gnt1", 32'(bus_a.gnt), 32'h1);
        chk("b2b_addr1", 32'(bus_a.rom_addr), 32'h0101);
        set_a(2'b00, 14'h0, 14'h0);
        step();
        chk("b2b_end", 32'(bus_a.gnt), 32'h0);
        drain("b2b");

        // Fixed priority: 2-requester alternation, 3-requester starvation of index 2
        do_reset();
        bus_b.req = 2'b11;
        bus_c.req = 3'b111;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("fp2_gnt", 32'(bus_b.gnt), (i % 2 == 0) ? 32'h1 : 32'h2);
            chk("fp3_gnt", 32'(bus_c.gnt), (i % 2 == 0) ? 32'h1 : 32'h2);
            chk("fp3_starve2", 32'(bus_c.gnt[2]), 32'h0);
        end
        bus_b.req = '0;
        bus_c.req = '0;
        step();
        step();
        chk("fp2_idle", 32'(bus_b.gnt), 32'h0);
        chk("fp3_idle", 32'(bus_c.gnt), 32'h0);
        drain("fp");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/rom_arbiter.md
Name: rom_arbiter

Overview:
- Shares one synchronous single-port ROM (1-cycle registered read, `ena` qualifies the read) between NUM_REQ requesters, e.g. Z80 instruction fetch and a video/tile fetch engine.
- Arbitrates per cycle, drives the ROM's enable and address, and returns each read's data with a one-hot valid to the winning requester.
- Fully pipelined: one ROM access can issue every cycle.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ADDR_W, 14, ROM address width.
- DATA_W, 8, ROM data width.
- RR_MODE, 1, 1 = round-robin arbitration; 0 = fixed priority (index 0 highest).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  per-requester read request, level.
- req_addr  in  NUM_REQ*ADDR_W  flattened addresses; requester i at [i*ADDR_W +: ADDR_W].
- gnt  out  NUM_REQ  one-hot grant pulse; request accepted.
- rvalid  out  NUM_REQ  one-hot read-data valid pulse.
- rdata  out  DATA_W  read data, shared by all requesters.
- rom_ena  out  1  to ROM `ena`.
- rom_addr  out  ADDR_W  to ROM `addr`.
- rom_dout  in  DATA_W  from ROM `dout`; registered inside the ROM.

Behaviour:
- Reset (async, rst_n=0):
  - gnt=0, rvalid=0, rom_ena=0, rom_addr=0, rdata=0.
  - In-flight pipeline stage cleared; any read in flight is dropped, and no rvalid is ever issued for it.
  - RR pointer `last` = NUM_REQ-1, so requester 0 wins first.
- Eligibility in cycle T:
  - eligible[i] = req[i] & ~gnt[i]. A requester seeing its own gnt in T is not eligible in T.
  - Same-requester throughput is therefore at most one access per 2 cycles.
  - Aggregate throughput is one access per cycle when two or more requesters alternate.
- Selection in cycle T, combinational from eligible:
  - RR_MODE=1: first eligible index searching last+1, last+2, … modulo NUM_REQ.
  - RR_MODE=0: lowest eligible index.
- Issue, registered at the end of T (winner w exists):
  - gnt = onehot(w), rom_ena = 1, rom_addr = req_addr[w].
  - `last` <= w, in RR mode only.
  - Stage-1 tag <= onehot(w).
- No eligible requester: gnt=0, rom_ena=0, rom_addr holds its previous value, `last` unchanged, tag=0.
- Read return:
  - The ROM captures in cycle T+1; rom_dout is valid in T+2.
  - In T+2, rvalid = tag delayed one cycle, i.e. rvalid[w]=1 in the cycle after gnt[w].
- rdata = rom_dout when |rvalid, else 0 (combinational gating). rdata is only meaningful with rvalid.
- Latency: req sampled high in T → gnt in T+1 → rvalid and data in T+2. Fixed, never stalls.
- Requester contract:
  - Hold req and req_addr stable until gnt is seen.
  - Drop req, or present the next address, in the cycle gnt is seen. The value in that cycle is ignored for that requester.
- req deasserted before being granted: the request is silently withdrawn, with no gnt.
- Simultaneous requests: exactly one gnt per cycle; losers stay pending with their address held.
- Round-robin guarantees a grant within NUM_REQ cycles of continuous assertion. Fixed priority may starve requesters; this is allowed.
- Assertions (sim only): gnt and rvalid one-hot-or-zero; rom_ena == |gnt.

Test Plan:
- ROM model with mem[a] = a[7:0] ^ 8'hA5, NUM_REQ=2, RR_MODE=1 unless stated.
- Single read: req[0]=1, addr 14'h0010 at T0, dropped on gnt → gnt=01 at T1 with rom_ena=1, rom_addr=0x0010; rvalid=01 and rdata=0xB5 at T2; all outputs then return to 0.
- Contention RR: req=11 held continuously, addr0=0x0001, addr1=0x0002 → gnt sequence 01,10,01,10 from T1; rvalid follows one cycle later; rdata alternates 0xA4, 0xA7 with no idle cycle.
- Fixed priority: RR_MODE=0, req=11 held, requester 0 re-requests after each gnt → gnt pattern 01,10,01,10. With a 3-requester build and req=111 held, requester 2 is never granted.
- Withdrawal: req[1] asserted for one cycle only, while requester 0 wins that cycle → no gnt[1], no rvalid[1]; rom_addr never equals addr1.
- Reset mid-flight: gnt=01 at T1, rst_n low in T1.5 for one cycle → rvalid stays 0 at T2; all outputs 0 during reset; the first grant after release goes to requester 0.
- Back-to-back same requester: req[0] held high through gnt → gnt[0] every other cycle only; each rvalid matches its address in order (0x0100 → 0xA5, 0x0101 → 0xA4).
